// File: rtl/stream_program_loader.sv
// rtl/stream_program_loader.sv - streams a length-prefixed, checksummed program image into program memory
module stream_program_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  run,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic                  load_done,
    output logic                  load_error,
    output logic [1:0]            err_code,
    output logic                  cpu_hold,
    output logic                  start_execution
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        LOAD   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(2 ** ADDR_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ONE_W   = DATA_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                state;
    logic [ADDR_WIDTH:0]   length;
    logic [DATA_WIDTH-1:0] accum;
    logic                  xfer;

    assign in_ready = (state == HEADER) || (state == LOAD) || (state == CHECK);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            length          <= '0;
            accum           <= '0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_data        <= '0;
            words_loaded    <= '0;
            load_done       <= 1'b0;
            load_error      <= 1'b0;
            err_code        <= 2'b00;
            cpu_hold        <= 1'b1;
            start_execution <= 1'b0;
        end else begin
            mem_we          <= 1'b0;
            start_execution <= 1'b0;
            // A restart wins over any word presented in the same cycle; that word is dropped.
            if (load_start) begin
                state        <= HEADER;
                words_loaded <= '0;
                accum        <= '0;
                load_done    <= 1'b0;
                load_error   <= 1'b0;
                err_code     <= 2'b00;
                cpu_hold     <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    HEADER: begin
                        if (xfer) begin
                            if (in_data >= ONE_W && in_data <= DEPTH_W) begin
                                length <= in_data[ADDR_WIDTH:0];
                                state  <= LOAD;
                            end else begin
                                state      <= ERROR;
                                load_error <= 1'b1;
                                err_code   <= 2'b01;
                            end
                        end
                    end
                    LOAD: begin
                        if (xfer) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
                            mem_data     <= in_data;
                            words_loaded <= words_loaded + CNT_ONE;
                            accum        <= accum + in_data;
                            // length never exceeds DEPTH, so the address stops at DEPTH-1.
                            if (words_loaded + CNT_ONE == length) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (xfer) begin
                            if (in_data == accum) begin
                                state     <= DONE;
                                load_done <= 1'b1;
                            end else begin
                                state      <= ERROR;
                                load_error <= 1'b1;
                                err_code   <= 2'b10;
                            end
                        end
                    end
                    DONE: begin
                        if (run && cpu_hold) begin
                            start_execution <= 1'b1;
                            cpu_hold        <= 1'b0;
                        end
                    end
                    ERROR: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_program_loader.sv
// tb/tb_stream_program_loader.sv - directed self-checking bench for stream_program_loader
module tb_stream_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        run = 1'b0;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_data;
    logic [5:0]  words_loaded;
    logic        load_done;
    logic        load_error;
    logic [1:0]  err_code;
    logic        cpu_hold;
    logic        start_execution;

    int checks = 0;
    int errors = 0;
    int nwrites = 0;
    int pulses = 0;

    stream_program_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .load_start(load_start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .run(run),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .words_loaded(words_loaded), .load_done(load_done), .load_error(load_error),
        .err_code(err_code), .cpu_hold(cpu_hold), .start_execution(start_execution)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_we === 1'b1) nwrites++;
        if (start_execution === 1'b1) pulses++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic begin_session();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 16'hAAAA;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0h exp 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0h exp 0", mem_we); end
        checks++; if (mem_addr !== 5'd0) begin errors++; $display("FAIL rst_mem_addr got %0h exp 0", mem_addr); end
        checks++; if (mem_data !== 16'h0000) begin errors++; $display("FAIL rst_mem_data got %0h exp 0", mem_data); end
        checks++; if (words_loaded !== 6'd0) begin errors++; $display("FAIL rst_words got %0d exp 0", words_loaded); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_done got %0h exp 0", load_done); end
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL rst_error got %0h exp 0", load_error); end
        checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL rst_err_code got %0h exp 0", err_code); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold got %0h exp 1", cpu_hold); end
        checks++; if (start_execution !== 1'b0) begin errors++; $display("FAIL rst_start got %0h exp 0", start_execution); end
        send(16'h0003);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_no_write got %0h exp 0", mem_we); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got %0h exp 0", in_ready); end
    endtask

    task automatic test_good_load();
        logic [15:0] pay [3];
        pay[0] = 16'h1234; pay[1] = 16'h0001; pay[2] = 16'hFFFF;
        begin_session();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL good_in_ready got %0h exp 1", in_ready); end
        send(16'd3);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL good_hdr_no_write got %0h exp 0", mem_we); end
        for (int i = 0; i < 3; i++) begin
            send(pay[i]);
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL good_we[%0d] got %0h exp 1", i, mem_we); end
            checks++; if (mem_addr !== 5'(i)) begin errors++; $display("FAIL good_addr[%0d] got %0d exp %0d", i, mem_addr, i); end
            checks++; if (mem_data !== pay[i]) begin errors++; $display("FAIL good_data[%0d] got %0h exp %0h", i, mem_data, pay[i]); end
            checks++; if (words_loaded !== 6'(i + 1)) begin errors++; $display("FAIL good_words[%0d] got %0d exp %0d", i, words_loaded, i + 1); end
        end
        send(16'h1234);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL good_done got %0h exp 1", load_done); end
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL good_error got %0h exp 0", load_error); end
        checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL good_err_code got %0h exp 0", err_code); end
        checks++; if (words_loaded !== 6'd3) begin errors++; $display("FAIL good_words_final got %0d exp 3", words_loaded); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL good_done_in_ready got %0h exp 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL good_chk_no_write got %0h exp 0", mem_we); end
    endtask

    task automatic test_run_done();
        int p0;
        p0 = pulses;
        run = 1'b1;
        tick();
        checks++; if (start_execution !== 1'b1) begin errors++; $display("FAIL run_pulse got %0h exp 1", start_execution); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL run_release got %0h exp 0", cpu_hold); end
        tick();
        checks++; if (start_execution !== 1'b0) begin errors++; $display("FAIL run_pulse_end got %0h exp 0", start_execution); end
        tick();
        run = 1'b0;
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL run_pulse_count got %0d exp %0d", pulses - p0, 1); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL run_done_held got %0h exp 1", load_done); end
    endtask

    task automatic test_bad_checksum();
        begin_session();
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL bad_ck_rehold got %0h exp 1", cpu_hold); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL bad_ck_done_clr got %0h exp 0", load_done); end
        send(16'd3); send(16'h1234); send(16'h0001); send(16'hFFFF);
        send(16'h0000);
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL bad_ck_error got %0h exp 1", load_error); end
        checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL bad_ck_code got %0h exp 2", err_code); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL bad_ck_done got %0h exp 0", load_done); end
        run = 1'b1;
        tick();
        run = 1'b0;
        checks++; if (start_execution !== 1'b0) begin errors++; $display("FAIL bad_ck_run got %0h exp 0", start_execution); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL bad_ck_hold got %0h exp 1", cpu_hold); end
    endtask

    task automatic test_bad_length();
        int w0;
        w0 = nwrites;
        begin_session();
        send(16'd0);
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL len0_error got %0h exp 1", load_error); end
        checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL len0_code got %0h exp 1", err_code); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len0_in_ready got %0h exp 0", in_ready); end
        begin_session();
        checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL len_restart_clr got %0h exp 0", err_code); end
        send(16'd33);
        checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL len33_code got %0h exp 1", err_code); end
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL len33_error got %0h exp 1", load_error); end
        send(16'h0007);
        tick();
        checks++; if (nwrites !== w0) begin errors++; $display("FAIL len_no_writes got %0d exp %0d", nwrites, w0); end
    endtask

    task automatic test_full();
        int w0;
        logic [15:0] sum;
        logic [15:0] d;
        w0 = nwrites;
        sum = 16'h0000;
        begin_session();
        send(16'd32);
        for (int i = 0; i < 32; i++) begin
            d = 16'(i * 16'h0803 + 16'h00A5);
            sum = sum + d;
            send(d);
            if (i == 31) begin
                checks++; if (mem_addr !== 5'd31) begin errors++; $display("FAIL full_last_addr got %0d exp 31", mem_addr); end
                checks++; if (mem_data !== d) begin errors++; $display("FAIL full_last_data got %0h exp %0h", mem_data, d); end
            end
        end
        checks++; if (words_loaded !== 6'd32) begin errors++; $display("FAIL full_words got %0d exp 32", words_loaded); end
        send(sum);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL full_done got %0h exp 1", load_done); end
        checks++; if (nwrites !== w0 + 32) begin errors++; $display("FAIL full_write_count got %0d exp %0d", nwrites - w0, 32); end
    endtask

    task automatic test_gaps();
        logic pat [6];
        int k;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
        k = 0;
        begin_session();
        send(16'd3);
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            in_data  = 16'h0A00 + 16'(i);
            tick();
            if (pat[i]) begin
                checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL gap_we[%0d] got %0h exp 1", i, mem_we); end
                checks++; if (mem_addr !== 5'(k)) begin errors++; $display("FAIL gap_addr[%0d] got %0d exp %0d", i, mem_addr, k); end
                checks++; if (mem_data !== 16'h0A00 + 16'(i)) begin errors++; $display("FAIL gap_data[%0d] got %0h exp %0h", i, mem_data, 16'h0A00 + 16'(i)); end
                k++;
            end else begin
                checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL gap_idle_we[%0d] got %0h exp 0", i, mem_we); end
            end
        end
        in_valid = 1'b0;
        send(16'h1E08);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL gap_done got %0h exp 1", load_done); end
        checks++; if (words_loaded !== 6'd3) begin errors++; $display("FAIL gap_words got %0d exp 3", words_loaded); end
    endtask

    task automatic test_start_priority();
        begin_session();
        send(16'd2);
        send(16'h0011);
        load_start = 1'b1; in_valid = 1'b1; in_data = 16'h0022;
        tick();
        load_start = 1'b0; in_valid = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL prio_no_write got %0h exp 0", mem_we); end
        checks++; if (words_loaded !== 6'd0) begin errors++; $display("FAIL prio_words got %0d exp 0", words_loaded); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_header got %0h exp 1", in_ready); end
        send(16'd1);
        send(16'h0055);
        checks++; if (mem_addr !== 5'd0) begin errors++; $display("FAIL prio_addr got %0d exp 0", mem_addr); end
        checks++; if (mem_data !== 16'h0055) begin errors++; $display("FAIL prio_data got %0h exp 55", mem_data); end
        send(16'h0055);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL prio_done got %0h exp 1", load_done); end
    endtask

    task automatic test_reset_mid();
        int w0;
        begin_session();
        send(16'd4); send(16'h0001); send(16'h0002);
        reset = 1'b1; in_valid = 1'b1; in_data = 16'h0003;
        tick();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %0h exp 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_we got %0h exp 0", mem_we); end
        checks++; if (mem_addr !== 5'd0) begin errors++; $display("FAIL mid_addr got %0d exp 0", mem_addr); end
        checks++; if (mem_data !== 16'h0000) begin errors++; $display("FAIL mid_data got %0h exp 0", mem_data); end
        checks++; if (words_loaded !== 6'd0) begin errors++; $display("FAIL mid_words got %0d exp 0", words_loaded); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL mid_hold got %0h exp 1", cpu_hold); end
        checks++; if ({load_done, load_error, err_code} !== 4'b0000) begin errors++; $display("FAIL mid_status got %0h exp 0", {load_done, load_error, err_code}); end
        w0 = nwrites;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'h0004 + 16'(i);
            tick();
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ignore_ready[%0d] got %0h exp 0", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (nwrites !== w0) begin errors++; $display("FAIL mid_no_writes got %0d exp %0d", nwrites, w0); end
        checks++; if (words_loaded !== 6'd0) begin errors++; $display("FAIL mid_words_after got %0d exp 0", words_loaded); end
    endtask

    task automatic test_run_idle();
        int p0;
        p0 = pulses;
        run = 1'b1;
        tick();
        checks++; if (start_execution !== 1'b0) begin errors++; $display("FAIL idle_run_pulse got %0h exp 0", start_execution); end
        tick();
        run = 1'b0;
        tick();
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL idle_run_hold got %0h exp 1", cpu_hold); end
        checks++; if (pulses !== p0) begin errors++; $display("FAIL idle_run_count got %0d exp %0d", pulses, p0); end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_run_done();
        test_bad_checksum();
        test_bad_length();
        test_full();
        test_gaps();
        test_start_priority();
        test_reset_mid();
        test_run_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_program_loader.md
STREAM_PROGRAM_LOADER -- requirements
Module: stream_program_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: instruction word width and checksum width.
REQ-002 Parameter ADDR_WIDTH, default 5: program memory address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Constraint: DATA_WIDTH SHALL be >= ADDR_WIDTH+1, so the header can encode DEPTH.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load_start  input  1  begins or restarts a load session.
REQ-007 in_data  input  DATA_WIDTH  stream word: header, then payload, then checksum.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 run  input  1  request to release the CPU after a good load.
REQ-011 mem_we  output  1  program memory write strobe.
REQ-012 mem_addr  output  ADDR_WIDTH  program memory write address.
REQ-013 mem_data  output  DATA_WIDTH  program memory write data.
REQ-014 words_loaded  output  ADDR_WIDTH+1  payload words written this session.
REQ-015 load_done  output  1  load completed and checksum matched.
REQ-016 load_error  output  1  session failed.
REQ-017 err_code  output  2  00 none, 01 bad length, 10 checksum mismatch.
REQ-018 cpu_hold  output  1  holds CPU idle while high.
REQ-019 start_execution  output  1  one-cycle CPU start pulse.

Function
REQ-020 The FSM SHALL have states IDLE, HEADER, LOAD, CHECK, DONE, ERROR.
REQ-021 A transfer SHALL occur only on a cycle where in_valid and in_ready are both high.
REQ-022 in_ready SHALL be high exactly in HEADER, LOAD and CHECK.
REQ-023 load_start in any state except HEADER SHALL move to HEADER next cycle and clear words_loaded, the checksum accumulator, load_done, load_error and err_code, and set cpu_hold=1.
REQ-024 load_start SHALL take priority over a transfer in the same cycle; that word SHALL be discarded.
REQ-025 HEADER: the transferred word is length N; if 1 <= N <= DEPTH, go to LOAD; otherwise go to ERROR with err_code=01.
REQ-026 LOAD: each transferred word SHALL produce one registered write one cycle later: mem_we=1, mem_addr=words_loaded (pre-increment value), mem_data=word.
REQ-027 LOAD: words_loaded SHALL increment per transfer, and the accumulator SHALL add the word modulo 2**DATA_WIDTH.
REQ-028 LOAD: after the Nth transfer, go to CHECK; address DEPTH-1 SHALL be the last legal write, with no wrap.
REQ-029 mem_we SHALL be 0 on every cycle not following a LOAD transfer; in_valid gaps SHALL produce no writes.
REQ-030 CHECK: if the transferred word equals the accumulator, go to DONE; otherwise go to ERROR with err_code=10.
REQ-031 DONE: load_done=1, held until load_start or reset.
REQ-032 ERROR: load_error=1, held until load_start or reset; cpu_hold stays 1.
REQ-033 run while in DONE with cpu_hold=1 SHALL produce start_execution=1 for exactly one cycle and clear cpu_hold on that same edge.
REQ-034 run in any other state, or when cpu_hold=0, SHALL be ignored.
REQ-035 A later load_start after release SHALL reassert cpu_hold.

Reset
REQ-036 On reset: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_data=0, words_loaded=0, load_done=0, load_error=0, err_code=00, cpu_hold=1, start_execution=0, accumulator=0.
REQ-037 Reset mid-session SHALL abort the session; no further writes, and the next session requires load_start.

Verification (DATA_WIDTH=16, ADDR_WIDTH=5)
REQ-038 Stimulus: load_start; header 3; payload 0x1234, 0x0001, 0xFFFF; checksum 0x1234. Response: writes addr0=0x1234, addr1=0x0001, addr2=0xFFFF; words_loaded=3; load_done=1; err_code=00.
REQ-039 Stimulus: same stream with checksum 0x0000. Response: load_error=1, err_code=10, load_done=0, cpu_hold=1.
REQ-040 Stimulus: header 0, then a separate session with header 33. Response: each gives ERROR with err_code=01 and no writes. Header 32 with 32 words: last write at addr 31, words_loaded=32.
REQ-041 Stimulus: in_valid toggling 1,0,0,1,0,1 during LOAD. Response: exactly three writes at consecutive addresses, each one cycle after its transfer.
REQ-042 Stimulus: reset asserted after the 2nd payload word. Response: all outputs at reset values on the next cycle; later stream words ignored until load_start.
REQ-043 Stimulus: run held 3 cycles in DONE, and run asserted in IDLE. Response: in DONE, a single start_execution pulse and cpu_hold=0; in IDLE, no pulse.
